// File: rtl/seq_playback_ctrl.sv
// -----------------------------------------------------------------------------
// seq_playback_ctrl
//
// Sequence game controller. Each round appends one random move to the stored
// sequence, plays the whole sequence back as timed tones, then checks the
// player's button presses against it. A wrong press loses the game. Completing
// a sequence of MAX_LEN moves wins it.
//
// Configuration macro:
//   SEQ_TIMEOUT_EN - when defined, TIMEOUT_TICKS ticks in the input-wait state
//                    without a press lose the game. When undefined the
//                    controller waits for input indefinitely.
//
// Parameters:
//   MAX_LEN       - maximum sequence length (2..32)
//   ON_TICKS      - ticks a playback tone is held on
//   OFF_TICKS     - ticks of silence after each playback tone
//   TIMEOUT_TICKS - player-input timeout in ticks (SEQ_TIMEOUT_EN only)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous reset, active low
//   tick        in   one-cycle timing strobe
//   start       in   one-cycle new-game request (IDLE/WIN/LOSE only)
//   rand_val    in   random move source; named rand_val because rand is a
//                    reserved word
//   btn_num     in   player button number
//   btn_pressed in   player press level
//   simon_turn  out  high while a move is added or the sequence is played back
//   out_num     out  move number to the LED/tone path
//   out_pressed out  LED/tone enable
//   game_over   out  high in the lose state
//   win         out  high in the win state
//   level       out  current sequence length
// -----------------------------------------------------------------------------
module seq_playback_ctrl #(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned ON_TICKS      = 2,
  parameter int unsigned OFF_TICKS     = 1,
  parameter int unsigned TIMEOUT_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [1:0] rand_val,
  input  logic [1:0] btn_num,
  input  logic       btn_pressed,
  output logic       simon_turn,
  output logic [1:0] out_num,
  output logic       out_pressed,
  output logic       game_over,
  output logic       win,
  output logic [5:0] level
);

  localparam int unsigned LenW = 6;
  localparam int unsigned IdxW = $clog2(MAX_LEN);

  // One tick counter is shared by every timed state, so it is sized for the
  // largest tick parameter.
  localparam int unsigned MaxOnOff = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned MaxTicks = (MaxOnOff > TIMEOUT_TICKS) ? MaxOnOff : TIMEOUT_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);

  localparam logic [CntW-1:0] OnLast  = CntW'(ON_TICKS - 1);
  localparam logic [CntW-1:0] OffLast = CntW'(OFF_TICKS - 1);
`ifdef SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StAdd,
    StPlayOn,
    StPlayOff,
    StWaitIn,
    StRelease,
    StWin,
    StLose
  } state_e;

  state_e            state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              btn_prev_q;
  logic              mem_we;
  logic              press;
  logic              idx_last;
  logic [1:0]        mem_rd;

  // Move storage. Not reset: every location is written by ADD before idx can
  // reach it, so stale contents are never visible.
  logic [1:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[len_q[IdxW-1:0]] <= rand_val;
    end
  end

  assign mem_rd = mem[idx_q];

  // A press is a rising edge of the button level. Because btn_prev_q tracks
  // the button in every state, a level held across entry into WAIT_IN has no
  // edge and is not taken as a press.
  assign press    = btn_pressed & ~btn_prev_q;
  assign idx_last = (LenW'(idx_q) == (len_q - LenW'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_pressed;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;

    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (start) begin
          len_d   = '0;
          idx_d   = '0;
          state_d = StAdd;
        end
      end

      StAdd: begin
        mem_we  = 1'b1;
        len_d   = len_q + LenW'(1);
        idx_d   = '0;
        state_d = StPlayOn;
      end

      StPlayOn: begin
        if (tick) begin
          if (cnt_q == OnLast) begin
            state_d = StPlayOff;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StPlayOff: begin
        if (tick) begin
          if (cnt_q == OffLast) begin
            if (idx_last) begin
              idx_d   = '0;
              state_d = StWaitIn;
            end else begin
              idx_d   = idx_q + IdxW'(1);
              state_d = StPlayOn;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StWaitIn: begin
        // A press wins over a timeout expiring in the same cycle.
        if (press) begin
          state_d = (btn_num == mem_rd) ? StRelease : StLose;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (tick) begin
          if (cnt_q == TimeoutLast) begin
            state_d = StLose;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
`endif
      end

      StRelease: begin
        if (!btn_pressed) begin
          if (!idx_last) begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StWaitIn;
          end else if (len_q == LenW'(MAX_LEN)) begin
            state_d = StWin;
          end else begin
            state_d = StAdd;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Every state starts its tick count from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // While the controller is not playing, the LED/tone path follows the player.
  always_comb begin
    simon_turn  = 1'b0;
    out_num     = btn_num;
    out_pressed = btn_pressed;
    unique case (state_q)
      StAdd: begin
        simon_turn  = 1'b1;
        out_num     = 2'b00;
        out_pressed = 1'b0;
      end
      StPlayOn: begin
        simon_turn  = 1'b1;
        out_num     = mem_rd;
        out_pressed = 1'b1;
      end
      StPlayOff: begin
        simon_turn  = 1'b1;
        out_num     = mem_rd;
        out_pressed = 1'b0;
      end
      default: ;
    endcase
  end

  assign game_over = (state_q == StLose);
  assign win       = (state_q == StWin);
  assign level     = len_q;

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_playback_ctrl
//
// Self-checking bench for seq_playback_ctrl. Two instances share all inputs:
// a default one (MAX_LEN=16) and a short one (MAX_LEN=2) for the win path.
// The expected sequence is kept in a queue; playback is observed as a list of
// tones with tick counts and compared against that queue.
// -----------------------------------------------------------------------------
module tb_seq_playback_ctrl;

  localparam int ON_T  = 2;
  localparam int OFF_T = 1;
  localparam int TO_T  = 8;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic [1:0] rand_val;
  logic [1:0] btn_num;
  logic       btn_pressed;

  logic       turn_m, pressed_m, go_m, win_m;
  logic [1:0] num_m;
  logic [5:0] level_m;
  logic       turn_w, pressed_w, go_w, win_w;
  logic [1:0] num_w;
  logic [5:0] level_w;

  bit         sel_w;
  logic       o_turn, o_pressed, o_go, o_win;
  logic [1:0] o_num;
  logic [5:0] o_level;

  assign o_turn    = sel_w ? turn_w    : turn_m;
  assign o_pressed = sel_w ? pressed_w : pressed_m;
  assign o_go      = sel_w ? go_w      : go_m;
  assign o_win     = sel_w ? win_w     : win_m;
  assign o_num     = sel_w ? num_w     : num_m;
  assign o_level   = sel_w ? level_w   : level_m;

  int n_pass;
  int n_total;
  int tick_mode;  // 0: no ticks, 1: random ticks, 2: tick every cycle
  logic [1:0] model_seq[$];

  seq_playback_ctrl #(
    .MAX_LEN(16), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .TIMEOUT_TICKS(TO_T)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .rand_val(rand_val),
    .btn_num(btn_num), .btn_pressed(btn_pressed), .simon_turn(turn_m),
    .out_num(num_m), .out_pressed(pressed_m), .game_over(go_m), .win(win_m),
    .level(level_m)
  );

  seq_playback_ctrl #(
    .MAX_LEN(2), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .TIMEOUT_TICKS(TO_T)
  ) dut_w (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .rand_val(rand_val),
    .btn_num(btn_num), .btn_pressed(btn_pressed), .simon_turn(turn_w),
    .out_num(num_w), .out_pressed(pressed_w), .game_over(go_w), .win(win_w),
    .level(level_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        0:       tick = 1'b0;
        1:       tick = ($urandom_range(0, 2) == 0);
        default: tick = 1'b1;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic apply_reset();
    reset = 1'b0;
    start = 1'b0;
    btn_pressed = 1'b0;
    btn_num = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_seq.delete();
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic press(input logic [1:0] num, input int hold);
    @(posedge clk);
    #1 btn_num = num;
    btn_pressed = 1'b1;
    repeat (hold) @(posedge clk);
    #1 btn_pressed = 1'b0;
    btn_num = 2'($urandom);
    @(negedge clk);
  endtask

  // Observes one ADD + playback phase and compares it with model_seq.
  task automatic run_playback(input string tag);
    int cyc;
    int add_cyc;
    bit in_tone;
    bit glitch;
    logic [1:0] nums[$];
    int ons[$];
    int offs[$];
    cyc = 0;
    @(negedge clk);
    while (o_turn !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (o_turn !== 1'b1) begin
      $display("FAIL %s turn_start: simon_turn=%b, required 1", tag, o_turn);
      return;
    end
    n_pass++;
    add_cyc = 0;
    in_tone = 0;
    glitch = 0;
    cyc = 0;
    while (o_turn === 1'b1 && cyc < 20000) begin
      if (o_pressed === 1'b1) begin
        if (!in_tone) begin
          nums.push_back(o_num);
          ons.push_back(0);
          offs.push_back(0);
          in_tone = 1;
        end else if (o_num !== nums[nums.size()-1]) begin
          glitch = 1;
        end
        if (tick) ons[ons.size()-1] = ons[ons.size()-1] + 1;
      end else if (nums.size() == 0) begin
        add_cyc++;
      end else begin
        in_tone = 0;
        if (tick) offs[offs.size()-1] = offs[offs.size()-1] + 1;
      end
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (add_cyc !== 1) $display("FAIL %s add_cycles: got %0d, required 1", tag, add_cyc);
    else n_pass++;
    n_total++;
    if (nums.size() !== model_seq.size() || glitch)
      $display("FAIL %s tone_count: got %0d (glitch=%0b), required %0d", tag, nums.size(),
               glitch, model_seq.size());
    else n_pass++;
    for (int i = 0; i < model_seq.size(); i++) begin
      n_total++;
      if (i >= nums.size())
        $display("FAIL %s tone%0d: missing, required num=%0d", tag, i, model_seq[i]);
      else if (nums[i] !== model_seq[i] || ons[i] !== ON_T || offs[i] !== OFF_T)
        $display("FAIL %s tone%0d: got num=%0d on=%0d off=%0d, required num=%0d on=%0d off=%0d",
                 tag, i, nums[i], ons[i], offs[i], model_seq[i], ON_T, OFF_T);
      else n_pass++;
    end
    n_total++;
    if (o_turn !== 1'b0 || o_level !== 6'(model_seq.size()) || o_go !== 1'b0)
      $display("FAIL %s wait_in: got turn=%b level=%0d go=%b, required turn=0 level=%0d go=0",
               tag, o_turn, o_level, o_go, model_seq.size());
    else n_pass++;
  endtask

  // Answers the whole stored sequence correctly; the next move is presented
  // on rand_val before the final release so ADD picks it up.
  task automatic player_round(input int max_len);
    logic [1:0] nxt;
    nxt = 2'($urandom);
    rand_val = nxt;
    for (int i = 0; i < model_seq.size(); i++) begin
      press(model_seq[i], $urandom_range(1, 3));
      n_total++;
      if (o_go !== 1'b0) $display("FAIL round press%0d: game_over=%b, required 0", i, o_go);
      else n_pass++;
    end
    if (model_seq.size() < max_len) model_seq.push_back(nxt);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    start = 1'b0;
    btn_pressed = 1'b0;
    btn_num = 2'b00;
    #1;
    n_total++;
    if ({o_turn, o_num, o_pressed, o_go, o_win, o_level} !== 12'b0)
      $display("FAIL reset_outputs: got %b, required all zero",
               {o_turn, o_num, o_pressed, o_go, o_win, o_level});
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b1;
    btn_num = 2'd3;
    btn_pressed = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if (o_turn !== 1'b0 || o_level !== 6'd0 || o_num !== 2'd3 || o_pressed !== 1'b1)
      $display("FAIL idle_passthrough: got turn=%b level=%0d num=%0d pressed=%b, required 0 0 3 1",
               o_turn, o_level, o_num, o_pressed);
    else n_pass++;
    btn_pressed = 1'b0;
    btn_num = 2'd0;
  endtask

  task automatic test_first_round();
    apply_reset();
    tick_mode = 1;
    rand_val = 2'd2;
    do_start();
    model_seq.push_back(2'd2);
    run_playback("first_round");
  endtask

  task automatic test_two_tone();
    apply_reset();
    tick_mode = 1;
    rand_val = 2'd2;
    do_start();
    model_seq.push_back(2'd2);
    run_playback("two_tone_r1");
    // start outside IDLE/WIN/LOSE must do nothing
    do_start();
    @(negedge clk);
    n_total++;
    if (o_turn !== 1'b0 || o_level !== 6'd1)
      $display("FAIL start_ignored: got turn=%b level=%0d, required 0 1", o_turn, o_level);
    else n_pass++;
    rand_val = 2'd0;
    press(2'd2, 2);
    model_seq.push_back(2'd0);
    run_playback("two_tone_r2");
    rand_val = 2'd1;
    press(2'd2, 1);
    press(2'd0, 3);
    model_seq.push_back(2'd1);
    run_playback("two_tone_r3");
  endtask

  task automatic test_lose();
    apply_reset();
    tick_mode = 1;
    rand_val = 2'd1;
    do_start();
    model_seq.push_back(2'd1);
    run_playback("lose_r1");
    @(posedge clk);
    #1 btn_num = 2'd3;
    btn_pressed = 1'b1;
    @(negedge clk);
    n_total++;
    if (o_go !== 1'b0) $display("FAIL lose_press_cycle: game_over=%b, required 0", o_go);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (o_go !== 1'b1) $display("FAIL lose_next_cycle: game_over=%b, required 1", o_go);
    else n_pass++;
    @(posedge clk);
    #1 btn_pressed = 1'b0;
    repeat (10) @(negedge clk);
    press(2'd1, 2);
    n_total++;
    if (o_go !== 1'b1 || o_turn !== 1'b0 || o_level !== 6'd1)
      $display("FAIL lose_sticky: got go=%b turn=%b level=%0d, required 1 0 1",
               o_go, o_turn, o_level);
    else n_pass++;
    rand_val = 2'd0;
    do_start();
    model_seq.delete();
    model_seq.push_back(2'd0);
    run_playback("lose_restart");
  endtask

  task automatic test_held();
    apply_reset();
    tick_mode = 1;
    rand_val = 2'd3;
    do_start();
    btn_num = 2'd0;
    btn_pressed = 1'b1;
    model_seq.push_back(2'd3);
    run_playback("held_r1");
    tick_mode = 0;
    repeat (5) @(negedge clk);
    n_total++;
    if (o_go !== 1'b0) $display("FAIL held_no_press: game_over=%b, required 0", o_go);
    else n_pass++;
    @(posedge clk);
    #1 btn_pressed = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (o_go !== 1'b0 || o_turn !== 1'b0)
      $display("FAIL held_release: got go=%b turn=%b, required 0 0", o_go, o_turn);
    else n_pass++;
    rand_val = 2'd1;
    press(2'd3, 1);
    model_seq.push_back(2'd1);
    tick_mode = 1;
    run_playback("held_r2");
  endtask

  task automatic test_win();
    sel_w = 1'b1;
    apply_reset();
    tick_mode = 1;
    rand_val = 2'($urandom);
    model_seq.push_back(rand_val);
    do_start();
    run_playback("win_r1");
    player_round(2);
    run_playback("win_r2");
    player_round(2);
    @(negedge clk);
    n_total++;
    if (o_win !== 1'b1 || o_level !== 6'd2 || o_go !== 1'b0 || o_turn !== 1'b0)
      $display("FAIL win_reached: got win=%b level=%0d go=%b turn=%b, required 1 2 0 0",
               o_win, o_level, o_go, o_turn);
    else n_pass++;
    for (int i = 0; i < 3; i++) press(2'($urandom), 1);
    n_total++;
    if (o_win !== 1'b1 || o_level !== 6'd2 || o_go !== 1'b0)
      $display("FAIL win_sticky: got win=%b level=%0d go=%b, required 1 2 0",
               o_win, o_level, o_go);
    else n_pass++;
    do_start();
    @(negedge clk);
    n_total++;
    if (o_win !== 1'b0 || o_turn !== 1'b1)
      $display("FAIL win_restart: got win=%b turn=%b, required 0 1", o_win, o_turn);
    else n_pass++;
    sel_w = 1'b0;
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    int cyc;
    apply_reset();
    tick_mode = 1;
    rand_val = 2'd1;
    do_start();
    model_seq.push_back(2'd1);
    run_playback("timeout_r1");
    cnt = 0;
    cyc = 0;
    while (o_go !== 1'b1 && cyc < 300) begin
      if (tick) cnt++;
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (o_go !== 1'b1 || cnt !== TO_T)
      $display("FAIL timeout_expiry: got go=%b after %0d ticks, required go=1 after %0d",
               o_go, cnt, TO_T);
    else n_pass++;
    // press on the expiring tick must be accepted
    apply_reset();
    rand_val = 2'd1;
    do_start();
    model_seq.push_back(2'd1);
    run_playback("timeout_r2");
    cnt = 0;
    cyc = 0;
    while (!(cnt == TO_T - 1 && tick) && cyc < 300) begin
      if (tick) cnt++;
      @(negedge clk);
      cyc++;
    end
    btn_num = 2'd1;
    btn_pressed = 1'b1;
    @(negedge clk);
    n_total++;
    if (o_go !== 1'b0) $display("FAIL timeout_press_priority: game_over=%b, required 0", o_go);
    else n_pass++;
    @(posedge clk);
    #1 btn_pressed = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (o_turn !== 1'b1 || o_go !== 1'b0)
      $display("FAIL timeout_press_accepted: got turn=%b go=%b, required 1 0", o_turn, o_go);
    else n_pass++;
  endtask
`else
  task automatic test_timeout();
    apply_reset();
    tick_mode = 1;
    rand_val = 2'd1;
    do_start();
    model_seq.push_back(2'd1);
    run_playback("no_timeout_r1");
    tick_mode = 2;
    repeat (40) @(negedge clk);
    n_total++;
    if (o_go !== 1'b0 || o_turn !== 1'b0)
      $display("FAIL no_timeout_wait: got go=%b turn=%b, required 0 0", o_go, o_turn);
    else n_pass++;
    tick_mode = 1;
  endtask
`endif

  task automatic test_reset_mid_play();
    int cyc;
    apply_reset();
    tick_mode = 1;
    rand_val = 2'd2;
    do_start();
    cyc = 0;
    @(negedge clk);
    while (o_pressed !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_total++;
    if (o_pressed !== 1'b0 || o_turn !== 1'b0 || o_level !== 6'd0 || o_num !== btn_num)
      $display("FAIL reset_mid_play: got pressed=%b turn=%b level=%0d num=%0d, required 0 0 0 %0d",
               o_pressed, o_turn, o_level, o_num, btn_num);
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (8) @(negedge clk);
    n_total++;
    if (o_turn !== 1'b0 || o_level !== 6'd0)
      $display("FAIL reset_stays_idle: got turn=%b level=%0d, required 0 0", o_turn, o_level);
    else n_pass++;
  endtask

  task automatic test_random_games();
    int target;
    int k;
    bit full;
    logic [1:0] wrong;
    for (int g = 0; g < 4; g++) begin
      apply_reset();
      tick_mode = 1;
      target = (g == 0) ? 16 : $urandom_range(2, 5);
      rand_val = 2'($urandom);
      model_seq.push_back(rand_val);
      do_start();
      for (int r = 0; r < 20; r++) begin
        run_playback($sformatf("game%0d_r%0d", g, r));
        if (model_seq.size() == target && target < 16) begin
          k = $urandom_range(0, model_seq.size() - 1);
          for (int i = 0; i < k; i++) press(model_seq[i], $urandom_range(1, 2));
          wrong = model_seq[k] ^ 2'($urandom_range(1, 3));
          @(posedge clk);
          #1 btn_num = wrong;
          btn_pressed = 1'b1;
          @(negedge clk);
          @(negedge clk);
          n_total++;
          if (o_go !== 1'b1 || o_level !== 6'(target))
            $display("FAIL game%0d_wrong_press: got go=%b level=%0d, required 1 %0d",
                     g, o_go, o_level, target);
          else n_pass++;
          @(posedge clk);
          #1 btn_pressed = 1'b0;
          break;
        end
        full = (model_seq.size() == 16);
        player_round(16);
        if (full) begin
          @(negedge clk);
          n_total++;
          if (o_win !== 1'b1 || o_level !== 6'd16 || o_go !== 1'b0)
            $display("FAIL game%0d_full_win: got win=%b level=%0d go=%b, required 1 16 0",
                     g, o_win, o_level, o_go);
          else n_pass++;
          break;
        end
      end
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    start = 1'b0;
    rand_val = 2'd0;
    btn_num = 2'd0;
    btn_pressed = 1'b0;
    sel_w = 1'b0;
    tick_mode = 1;
    repeat (2) @(posedge clk);
    test_reset();
    test_first_round();
    test_two_tone();
    test_lose();
    test_held();
    test_win();
    test_timeout();
    test_reset_mid_play();
    test_random_games();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
